// File: rtl/camera_pkg.sv
// Shared constants and helpers for the camera pixel path blocks.
package camera_pkg;

  localparam int DefaultDw   = 36;
  localparam int DefaultXdef = 160;

  // Ceiling log2, usable in parameter and port width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/camera_linering_ram.sv
// Simple dual-port line storage: one write port, one registered read port.
module camera_linering_ram
  import camera_pkg::*;
#(
  parameter int DW    = DefaultDw,
  parameter int DEPTH = 4096,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic [DW-1:0] rdData
);

  logic [DW-1:0] mem [DEPTH];

  // Array write port; the stored words are never reset or cleared.
  always_ff @(posedge CLOCK) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // Registered read port that holds its last word while not enabled.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)    rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/camera_linering.sv
// Multi-line ring buffer: reads are only granted on completed lines.
module camera_linering
  import camera_pkg::*;
#(
  parameter int DW    = DefaultDw,
  parameter int XMAX  = 1024,
  parameter int XDEF  = DefaultXdef,
  parameter int NLINE = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   iClear,
  input  logic [clog2(XMAX):0]   iXSize,
  input  logic                   iWrEn,
  input  logic [DW-1:0]          iData,
  input  logic                   iRdEn,
  output logic [DW-1:0]          oData,
  output logic                   oValid,
  output logic [clog2(NLINE):0]  oLines,
  output logic                   oLineReady,
  output logic                   oFull,
  output logic                   oOverflow,
  output logic                   oUnderflow
);

  localparam int ColW  = clog2(XMAX);
  localparam int SlotW = clog2(NLINE);
  localparam int XsW   = ColW + 1;
  localparam int CntW  = SlotW + 1;

  logic [ColW-1:0]  wrCol, rdCol;
  logic [SlotW-1:0] wrSlot, rdSlot;
  logic [CntW-1:0]  lineCount;
  logic [XsW-1:0]   xs, lastCol, xsRequest;
  logic             full, empty, idle;
  logic             writeAccept, readAccept, wrLineDone, rdLineDone;

  // Accept/refuse decisions and line-boundary detection from pre-edge state.
  always_comb begin
    full        = (lineCount == CntW'(NLINE));
    empty       = (lineCount == '0);
    idle        = empty && (wrCol == '0) && (rdCol == '0);
    writeAccept = iWrEn && !full && !iClear;
    readAccept  = iRdEn && !empty && !iClear;
    lastCol     = xs - XsW'(1);
    wrLineDone  = writeAccept && ({1'b0, wrCol} == lastCol);
    rdLineDone  = readAccept && ({1'b0, rdCol} == lastCol);
    xsRequest   = ((iXSize == '0) || (iXSize > XsW'(XMAX))) ? XsW'(XMAX) : iXSize;
    oLines      = lineCount;
    oLineReady  = !empty;
    oFull       = full;
  end

  // Column/slot counters, line count, flags and active line length.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wrCol      <= '0;
      wrSlot     <= '0;
      rdCol      <= '0;
      rdSlot     <= '0;
      lineCount  <= '0;
      oValid     <= 1'b0;
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
      xs         <= XsW'(XDEF);
    end else if (iClear) begin
      wrCol      <= '0;
      wrSlot     <= '0;
      rdCol      <= '0;
      rdSlot     <= '0;
      lineCount  <= '0;
      oValid     <= 1'b0;
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
      xs         <= xsRequest;
    end else begin
      if (writeAccept) begin
        if (wrLineDone) begin
          wrCol  <= '0;
          wrSlot <= wrSlot + SlotW'(1);
        end else begin
          wrCol <= wrCol + ColW'(1);
        end
      end
      if (readAccept) begin
        if (rdLineDone) begin
          rdCol  <= '0;
          rdSlot <= rdSlot + SlotW'(1);
        end else begin
          rdCol <= rdCol + ColW'(1);
        end
      end
      lineCount <= lineCount + CntW'(wrLineDone) - CntW'(rdLineDone);
      oValid    <= readAccept;
      if (iWrEn && full)  oOverflow  <= 1'b1;
      if (iRdEn && empty) oUnderflow <= 1'b1;
      if (idle)           xs         <= xsRequest;
    end
  end

  camera_linering_ram #(
    .DW    (DW),
    .DEPTH (NLINE * XMAX)
  ) ram (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .wrEn   (writeAccept),
    .wrAddr ({wrSlot, wrCol}),
    .wrData (iData),
    .rdEn   (readAccept),
    .rdAddr ({rdSlot, rdCol}),
    .rdData (oData)
  );

endmodule

// File: tb/tb_camera_linering.sv
// Scoreboard bench for camera_linering with directed vectors.
module tb_camera_linering;

  localparam int DW = 36;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          iClear = 1'b0;
  logic [10:0]   iXSize = 11'd160;
  logic          iWrEn = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          iRdEn = 1'b0;
  logic [DW-1:0] oData;
  logic          oValid;
  logic [2:0]    oLines;
  logic          oLineReady, oFull, oOverflow, oUnderflow;

  logic [DW-1:0] expQ[$];
  int total = 0;
  int bad = 0;
  int validCount = 0;

  camera_linering dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .iClear     (iClear),
    .iXSize     (iXSize),
    .iWrEn      (iWrEn),
    .iData      (iData),
    .iRdEn      (iRdEn),
    .oData      (oData),
    .oValid     (oValid),
    .oLines     (oLines),
    .oLineReady (oLineReady),
    .oFull      (oFull),
    .oOverflow  (oOverflow),
    .oUnderflow (oUnderflow)
  );

  // Free-running clock.
  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // One clock of stimulus; queues the word the read should return.
  task automatic applyStimulus(input logic wr, input logic [DW-1:0] wd, input logic rd,
                               input logic expectRead, input logic [DW-1:0] expData);
    iWrEn = wr;
    iData = wd;
    iRdEn = rd;
    if (expectRead) expQ.push_back(expData);
    @(posedge CLOCK);
    #1;
    iWrEn = 1'b0;
    iRdEn = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic drainCheck(input string name);
    idleCycles(2);
    checkOutput(name, DW'(expQ.size()), '0);
  endtask

  // Monitor: every valid output word is matched against the scoreboard.
  always @(negedge CLOCK) begin
    if (RESET && oValid) begin
      validCount++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedValid: got oData=%0d, required no valid word", oData);
      end else begin
        checkOutput("readData", oData, expQ.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting");
    #12;
    checkOutput("resetLines", oLines, 0);
    checkOutput("resetValid", oValid, 0);
    checkOutput("resetData", oData, 0);
    checkOutput("resetReady", oLineReady, 0);
    checkOutput("resetFull", oFull, 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b1;

    // One 160-word line written, then read back.
    for (int i = 0; i < 160; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, '0);
    checkOutput("oneLineCount", oLines, 1);
    checkOutput("oneLineReady", oLineReady, 1);
    validCount = 0;
    for (int i = 0; i < 160; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, DW'(i));
    idleCycles(1);
    checkOutput("oneLineEmpty", oLines, 0);
    checkOutput("validCycles", DW'(validCount), 160);
    drainCheck("drainOneLine");

    // Fill all four slots, then three dropped writes.
    for (int i = 0; i < 640; i++) applyStimulus(1'b1, DW'(1000 + i), 1'b0, 1'b0, '0);
    checkOutput("fullFlag", oFull, 1);
    checkOutput("fullLines", oLines, 4);
    checkOutput("noOverflowYet", oOverflow, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(9999), 1'b0, 1'b0, '0);
    checkOutput("overflowSet", oOverflow, 1);
    checkOutput("fullLinesAfterDrop", oLines, 4);
    for (int i = 0; i < 640; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, DW'(1000 + i));
    idleCycles(1);
    checkOutput("fullDrained", oLines, 0);
    checkOutput("overflowSticky", oOverflow, 1);
    drainCheck("drainFull");

    // Read with nothing stored, then clear.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("underflowSet", oUnderflow, 1);
    checkOutput("underflowValid", oValid, 0);
    checkOutput("underflowHold", oData, 1639);
    iClear = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    iClear = 1'b0;
    checkOutput("clearUnderflow", oUnderflow, 0);
    checkOutput("clearOverflow", oOverflow, 0);
    checkOutput("clearHoldData", oData, 1639);

    // Concurrent streaming of 8-word lines with a one-line lead.
    iXSize = 11'd8;
    idleCycles(1);
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, DW'(2000 + c), 1'b0, 1'b0, '0);
    checkOutput("streamLead", oLines, 1);
    for (int k = 1; k < 20; k++) begin
      for (int c = 0; c < 8; c++)
        applyStimulus(1'b1, DW'(2000 + k * 8 + c), 1'b1, 1'b1, DW'(2000 + (k - 1) * 8 + c));
      checkOutput("streamLines", oLines, 1);
    end
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, '0, 1'b1, 1'b1, DW'(2000 + 19 * 8 + c));
    checkOutput("streamEmpty", oLines, 0);
    drainCheck("drainStream");

    // Zero length request selects the maximum line length.
    iXSize = 11'd0;
    idleCycles(1);
    for (int i = 0; i < 1023; i++) applyStimulus(1'b1, DW'(3000 + i), 1'b0, 1'b0, '0);
    checkOutput("maxLenPartial", oLines, 0);
    applyStimulus(1'b1, DW'(3000 + 1023), 1'b0, 1'b0, '0);
    checkOutput("maxLenDone", oLines, 1);
    for (int i = 0; i < 1024; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, DW'(3000 + i));
    drainCheck("drainMaxLen");

    // Length request during a partial line waits for a clear.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(4000 + i), 1'b0, 1'b0, '0);
    iXSize = 11'd12;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, DW'(4005 + i), 1'b0, 1'b0, '0);
    checkOutput("xsHeldMidLine", oLines, 0);
    iClear = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    iClear = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, DW'(5000 + i), 1'b0, 1'b0, '0);
    checkOutput("xsAfterClear", oLines, 1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, DW'(5000 + i));
    drainCheck("drainShort");

    // Asynchronous reset in the middle of a line.
    iXSize = 11'd160;
    idleCycles(1);
    for (int i = 0; i < 370; i++) applyStimulus(1'b1, DW'(6000 + i), 1'b0, 1'b0, '0);
    checkOutput("preResetLines", oLines, 2);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("asyncResetData", oData, 0);
    checkOutput("asyncResetLines", oLines, 0);
    checkOutput("asyncResetReady", oLineReady, 0);
    checkOutput("asyncResetValid", oValid, 0);
    @(negedge CLOCK);
    RESET = 1'b1;
    for (int i = 0; i < 160; i++) applyStimulus(1'b1, DW'(7000 + i), 1'b0, 1'b0, '0);
    checkOutput("postResetLine", oLines, 1);
    for (int i = 0; i < 160; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, DW'(7000 + i));
    drainCheck("drainPostReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
